// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_tick;

  // Next count: reload on state entry, otherwise wrap at the end of the bit.
  always_comb begin
    w_cnt_next = r_cnt;
    if (restart) begin
      w_cnt_next = ZERO;
    end else if (r_cnt == LAST) begin
      w_cnt_next = ZERO;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Tick is registered from the next count so it is high exactly while r_cnt == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= ZERO;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and serializes them as 8N1 / 8E1 UART frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 ready,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_next_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_next_shift;
  logic                 r_parity;
  logic                 w_next_parity;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           w_next_bit_cnt;
  logic                 w_tick;
  logic                 w_restart;
  logic                 w_start_ok;
  logic                 w_next_tx;
  logic                 r_tx;
  logic                 r_rd;
  logic                 r_busy;

  assign w_start_ok = ready && enable;
  assign w_restart  = (w_next_state != r_state);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(w_restart),
    .tick   (w_tick)
  );

  // Frame sequencing plus next values of the shift register, parity and bit counter.
  always_comb begin
    w_next_state   = r_state;
    w_next_shift   = r_shift;
    w_next_parity  = r_parity;
    w_next_bit_cnt = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_next_state = FETCH;
        end else begin
          w_next_state = IDLE;
        end
      end
      FETCH: begin
        w_next_state = LOAD;
      end
      LOAD: begin
        w_next_shift   = data_in;
        w_next_parity  = PARITY_EN ? even_parity(data_in) : 1'b0;
        w_next_bit_cnt = 3'd0;
        w_next_state   = START;
      end
      START: begin
        if (w_tick) begin
          w_next_state = DATA;
        end else begin
          w_next_state = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_next_shift   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_next_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt != LAST_BIT) begin
            w_next_state = DATA;
          end else if (PARITY_EN) begin
            w_next_state = PARITY;
          end else begin
            w_next_state = STOP;
          end
        end else begin
          w_next_state = DATA;
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_next_state = STOP;
        end else begin
          w_next_state = PARITY;
        end
      end
      STOP: begin
        // Back-to-back frames chain straight into FETCH from the last stop cycle.
        if (!w_tick) begin
          w_next_state = STOP;
        end else if (w_start_ok) begin
          w_next_state = FETCH;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, so tx can be driven straight from a flop.
  always_comb begin
    w_next_tx = IDLE_LEVEL;
    case (w_next_state)
      START:   w_next_tx = START_LEVEL;
      DATA:    w_next_tx = w_next_shift[0];
      PARITY:  w_next_tx = w_next_parity;
      default: w_next_tx = IDLE_LEVEL;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= {DATA_BITS{1'b0}};
      r_parity  <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_tx      <= IDLE_LEVEL;
      r_rd      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_shift   <= w_next_shift;
      r_parity  <= w_next_parity;
      r_bit_cnt <= w_next_bit_cnt;
      r_tx      <= w_next_tx;
      r_rd      <= (w_next_state == FETCH);
      r_busy    <= (w_next_state != IDLE);
    end
  end

  assign tx         = r_tx;
  assign rd         = r_rd;
  assign busy       = r_busy;
  assign frame_done = (r_state == STOP) && w_tick;

endmodule
